// File: rtl/cam_match_encoder.sv
// Purpose : encode a CAM match-line vector into word addresses, lowest index first.
// Latency : search accepted at edge N gives its first result in cycle N+1; one result per cycle under sustained ready.
// Backpres: result held stable while result_ready_i=0; search_ready_o low until the last result is accepted.
//
// Optional feature macro: CAM_MULTI_HIT_ITER_EN
//   defined   -> every set match bit is reported in ascending index order.
//   undefined -> one result per search (lowest hit or the no-hit result);
//                multi_hit_o still flags multiple matches.
//
// Ports:
//   clk_i, reset_i              clock and synchronous active-high reset
//   search_valid_i/_ready_o     search handshake, match_lines_i is the vector
//   result_valid_o/_ready_i     result handshake
//   result_address_o            index of the lowest pending match bit
//   result_hit_o                at least one match pending
//   result_last_o               final result of this search
//   multi_hit_o                 captured vector had two or more bits set
module cam_match_encoder #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              search_valid_i,
  output logic              search_ready_o,
  input  logic [WORDS-1:0]  match_lines_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ADDR_W-1:0] result_address_o,
  output logic              result_hit_o,
  output logic              result_last_o,
  output logic              multi_hit_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [WORDS-1:0] ONE = {{(WORDS-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [WORDS-1:0] pending;
  logic             multi;

  logic              scan;
  logic [ADDR_W-1:0] low_addr;
  logic [WORDS-1:0]  pending_rest;
  logic              at_most_one;
  logic              match_multi;
  logic              last_raw;

  assign scan = (state == ST_SCAN);

  // Priority encoder: walking from the top down lets the lowest set bit win.
  always_comb begin
    low_addr = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_addr = ADDR_W'(i);
      end
    end
  end

  // x & (x-1) drops the lowest set bit; a zero remainder means at most one bit was set.
  assign pending_rest = pending & (pending - ONE);
  assign at_most_one  = ~|pending_rest;
  assign match_multi  = |(match_lines_i & (match_lines_i - ONE));

`ifdef CAM_MULTI_HIT_ITER_EN
  assign last_raw = at_most_one;
`else
  assign last_raw = 1'b1;
`endif

  // All outputs come from registered state only, gated to zero outside SCAN.
  assign search_ready_o   = ~scan;
  assign result_valid_o   = scan;
  assign result_address_o = scan ? low_addr : '0;
  assign result_hit_o     = scan & (|pending);
  assign result_last_o    = scan & last_raw;
  assign multi_hit_o      = scan & multi;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      pending <= '0;
      multi   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (search_valid_i) begin
            pending <= match_lines_i;
            multi   <= match_multi;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (result_ready_i) begin
            pending <= pending_rest;
            if (last_raw) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_match_encoder.sv
// Purpose : self-checking bench for cam_match_encoder (directed table, corner sequences, random searches).
// Latency : results expected one cycle after search acceptance, one per accepted handshake.
// Backpres: random stalls on result_ready; outputs must hold steady while stalled.
module tb_cam_match_encoder;

`ifdef CAM_MULTI_HIT_ITER_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        search_valid;
  logic        search_ready;
  logic [31:0] match_lines;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  result_address;
  logic        result_hit;
  logic        result_last;
  logic        multi_hit;

  int total = 0;
  int bad   = 0;

  cam_match_encoder #(.WORDS(32), .ADDR_W(5)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .search_valid_i   (search_valid),
    .search_ready_o   (search_ready),
    .match_lines_i    (match_lines),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready),
    .result_address_o (result_address),
    .result_hit_o     (result_hit),
    .result_last_o    (result_last),
    .multi_hit_o      (multi_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, search_ready, 1);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_addr"},  result_address, 0);
    check({tag, "_hit"},   result_hit, 0);
    check({tag, "_last"},  result_last, 0);
    check({tag, "_multi"}, multi_hit, 0);
  endtask

  // Drives one search and checks every result against a list of set-bit
  // indices built directly from the vector.
  task automatic run_search(input logic [31:0] vec, input int first_stall, input bit rand_stall,
                            output int first_addr, output int first_hit,
                            output int first_multi, output int nres);
    int q_addr[$];
    int exp_hit;
    int exp_multi;
    int waited;
    int stall;
    nres = 0;
    first_addr = -1; first_hit = -1; first_multi = -1;

    waited = 0;
    while (search_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (search_ready !== 1'b1) begin
      check("search_ready_timeout", search_ready, 1);
      return;
    end

    search_valid = 1'b1;
    match_lines  = vec;
    result_ready = 1'b0;
    @(negedge clk);
    search_valid = 1'b0;
    match_lines  = $urandom;   // captured vector must not depend on the bus any more

    for (int b = 0; b < 32; b++) if (vec[b]) q_addr.push_back(b);
    exp_multi = ($countones(vec) > 1) ? 1 : 0;
    exp_hit   = (q_addr.size() > 0) ? 1 : 0;
    if (q_addr.size() == 0) q_addr.push_back(0);
    if (!ITER) while (q_addr.size() > 1) void'(q_addr.pop_back());

    for (int k = 0; k < q_addr.size(); k++) begin
      stall = (k == 0) ? first_stall : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= stall; s++) begin
        result_ready = (s == stall);
        search_valid = $urandom_range(0, 1);   // must be ignored while scanning
        match_lines  = $urandom;
        if (k == 0 && s == 0) begin
          first_addr  = result_address;
          first_hit   = result_hit;
          first_multi = multi_hit;
        end
        check("res_valid", result_valid, 1);
        check("res_sready", search_ready, 0);
        check("res_addr", result_address, q_addr[k]);
        check("res_hit", result_hit, exp_hit);
        check("res_last", result_last, (k == q_addr.size() - 1) ? 1 : 0);
        check("res_multi", multi_hit, exp_multi);
        if (s == stall && result_valid === 1'b1) nres++;
        @(negedge clk);
      end
    end
    result_ready = 1'b0;
    search_valid = 1'b0;
    check_idle_outputs("after_last");
  endtask

  typedef struct {
    logic [31:0] vec;
    int          stall;
    int          addr;
    int          hit;
    int          multi;
    int          cnt_iter;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int fa, fh, fm, n;
    logic [31:0] rv;

    tbl[0] = '{32'h0000_0002, 0,  1, 1, 0, 1};
    tbl[1] = '{32'h0000_0000, 0,  0, 0, 0, 1};
    tbl[2] = '{32'h8000_0005, 3,  0, 1, 1, 3};
    tbl[3] = '{32'h0000_F000, 1, 12, 1, 1, 4};
    tbl[4] = '{32'h8000_0000, 2, 31, 1, 0, 1};
    tbl[5] = '{32'hFFFF_FFFF, 0,  0, 1, 1, 32};

    reset = 1'b1; search_valid = 1'b0; match_lines = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      run_search(tbl[t].vec, tbl[t].stall, 1'b0, fa, fh, fm, n);
      check("tbl_first_addr", fa, tbl[t].addr);
      check("tbl_first_hit", fh, tbl[t].hit);
      check("tbl_multi", fm, tbl[t].multi);
      check("tbl_count", n, ITER ? tbl[t].cnt_iter : 1);
    end

    // Reset in the middle of a scan discards the rest of the search.
    search_valid = 1'b1; match_lines = 32'h0000_F000;
    @(negedge clk);
    search_valid = 1'b0; result_ready = 1'b1;
    check("mid_first_addr", result_address, 12);
    check("mid_first_valid", result_valid, 1);
    @(negedge clk);
    result_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    check_idle_outputs("mid_reset_hold");
    run_search(32'h0000_0001, 0, 1'b0, fa, fh, fm, n);
    check("post_reset_addr", fa, 0);
    check("post_reset_hit", fh, 1);
    check("post_reset_count", n, 1);

    // Random searches with sparse vectors and random stalls.
    for (int r = 0; r < 40; r++) begin
      rv = $urandom & $urandom & $urandom;
      if (r % 9 == 0) rv = '0;
      run_search(rv, int'($urandom_range(0, 2)), 1'b1, fa, fh, fm, n);
      check("rand_count", n, ITER ? ((rv == 0) ? 1 : $countones(rv)) : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
